// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Holds the NOP encoding, the default vectors and the per-edge action encoding.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
    localparam int          INSTR_W              = 32;

    typedef enum logic [1:0] {
        ACT_ADVANCE  = 2'd0,
        ACT_STALL    = 2'd1,
        ACT_REDIRECT = 2'd2
    } fetch_action_t;

    function automatic logic word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_register.sv
// Program counter register: async reset to a parameter value, enable, and
// a select between the sequential increment and an externally loaded target.
module pc_register #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VALUE = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_val_i,
    input  logic [XLEN-1:0] inc_val_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (en_i) begin
            pc_d = load_i ? load_val_i : inc_val_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_VALUE;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem word address, IF/ID register, redirect
// handling with misaligned-target trapping, and a retired-fetch counter.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              IMEM_AW      = 8,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [XLEN-1:0]    redirect_pc_i,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic [31:0]        imem_rdata_i,
    output logic               ifid_valid_o,
    output logic [XLEN-1:0]    ifid_pc_o,
    output logic [XLEN-1:0]    ifid_pc4_o,
    output logic [31:0]        ifid_instr_o,
    output logic               fault_o,
    output logic [XLEN-1:0]    fault_pc_o,
    output logic [XLEN-1:0]    fetch_cnt_o
);

    fetch_action_t action;
    logic          target_ok;
    logic          pc_en;
    logic          pc_load;
    logic [XLEN-1:0] pc_load_val;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;

    logic               ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0]    ifid_pc_q,    ifid_pc_d;
    logic [XLEN-1:0]    ifid_pc4_q,   ifid_pc4_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic               fault_q,      fault_d;
    logic [XLEN-1:0]    fault_pc_q,   fault_pc_d;
    logic [XLEN-1:0]    fetch_cnt_q,  fetch_cnt_d;

    // Redirect wins over stall: a taken branch squashes whatever caused the hazard.
    always_comb begin
        action = ACT_ADVANCE;
        if (redirect_i) begin
            action = ACT_REDIRECT;
        end else if (stall_i) begin
            action = ACT_STALL;
        end
    end

    assign target_ok   = word_aligned(redirect_pc_i[1:0]);
    assign pc_en       = (action != ACT_STALL);
    assign pc_load     = (action == ACT_REDIRECT);
    assign pc_load_val = target_ok ? redirect_pc_i : TRAP_VECTOR;
    assign pc_plus4    = pc + XLEN'(4);

    pc_register #(
        .XLEN        (XLEN),
        .RESET_VALUE (RESET_VECTOR)
    ) u_pc_register (
        .clk        (clk),
        .reset      (reset),
        .en_i       (pc_en),
        .load_i     (pc_load),
        .load_val_i (pc_load_val),
        .inc_val_i  (pc_plus4),
        .pc_o       (pc)
    );

    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        fault_d      = 1'b0;
        fault_pc_d   = fault_pc_q;
        fetch_cnt_d  = fetch_cnt_q;
        unique case (action)
            ACT_REDIRECT: begin
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP_INSTR;
                if (!target_ok) begin
                    fault_d    = 1'b1;
                    fault_pc_d = redirect_pc_i;
                end
            end
            ACT_STALL: begin
            end
            default: begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = pc;
                ifid_pc4_d   = pc_plus4;
                ifid_instr_d = imem_rdata_i;
                fetch_cnt_d  = fetch_cnt_q + XLEN'(1);
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_instr_q <= NOP_INSTR;
            fault_q      <= 1'b0;
            fault_pc_q   <= '0;
            fetch_cnt_q  <= '0;
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            fault_q      <= fault_d;
            fault_pc_q   <= fault_pc_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    // Upper PC bits beyond the imem depth are dropped, so fetches alias.
    assign imem_addr_o  = pc[IMEM_AW+1:2];
    assign ifid_valid_o = ifid_valid_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_pc4_o   = ifid_pc4_q;
    assign ifid_instr_o = ifid_instr_q;
    assign fault_o      = fault_q;
    assign fault_pc_o   = fault_pc_q;
    assign fetch_cnt_o  = fetch_cnt_q;

    // Both vectors must be word-aligned; a bad vector shows up here as a misaligned PC.
    a_pc_aligned: assert property (@(posedge clk) disable iff (reset) pc[1:0] == 2'b00);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized stall/redirect/reset
// traffic, checked every cycle against a behavioural model of the fetch rules.
module tb_fetch_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] TRAP = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] target = '0;

    logic [7:0]  a_addr;
    logic [31:0] a_rdata, a_ifpc, a_ifpc4, a_instr, a_fpc, a_cnt;
    logic        a_valid, a_fault;
    logic [3:0]  b_addr;
    logic [31:0] b_rdata, b_ifpc, b_ifpc4, b_instr, b_fpc, b_cnt;
    logic        b_valid, b_fault;

    logic [31:0] imem8 [256];
    logic [31:0] imem4 [16];

    assign a_rdata = imem8[a_addr];
    assign b_rdata = imem4[b_addr];

    fetch_unit #(.XLEN(32), .IMEM_AW(8)) dut (
        .clk(clk), .reset(reset), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(target), .imem_addr_o(a_addr), .imem_rdata_i(a_rdata),
        .ifid_valid_o(a_valid), .ifid_pc_o(a_ifpc), .ifid_pc4_o(a_ifpc4),
        .ifid_instr_o(a_instr), .fault_o(a_fault), .fault_pc_o(a_fpc),
        .fetch_cnt_o(a_cnt)
    );

    fetch_unit #(.XLEN(32), .IMEM_AW(4)) dut_small (
        .clk(clk), .reset(reset), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(target), .imem_addr_o(b_addr), .imem_rdata_i(b_rdata),
        .ifid_valid_o(b_valid), .ifid_pc_o(b_ifpc), .ifid_pc4_o(b_ifpc4),
        .ifid_instr_o(b_instr), .fault_o(b_fault), .fault_pc_o(b_fpc),
        .fetch_cnt_o(b_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr8, m_instr4, m_fpc, m_cnt;
    logic        m_valid, m_fault;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pc = 32'h0; m_valid = 1'b0; m_ifpc = '0; m_ifpc4 = '0;
        m_instr8 = NOP; m_instr4 = NOP; m_fault = 1'b0; m_fpc = '0; m_cnt = '0;
    endtask

    task automatic step_model();
        if (reset) begin
            m_reset();
        end else if (redirect) begin
            m_valid = 1'b0; m_instr8 = NOP; m_instr4 = NOP;
            if (target[1:0] == 2'b00) begin
                m_pc = target; m_fault = 1'b0;
            end else begin
                m_pc = TRAP; m_fault = 1'b1; m_fpc = target;
            end
        end else if (stall) begin
            m_fault = 1'b0;
        end else begin
            m_valid  = 1'b1;
            m_ifpc   = m_pc;
            m_ifpc4  = m_pc + 32'd4;
            m_instr8 = imem8[m_pc[9:2]];
            m_instr4 = imem4[m_pc[5:2]];
            m_cnt    = m_cnt + 32'd1;
            m_pc     = m_pc + 32'd4;
            m_fault  = 1'b0;
        end
    endtask

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic cycle(input logic st, input logic rd, input logic [31:0] tg);
        stall = st; redirect = rd; target = tg;
        @(posedge clk);
        step_model();
        #1;
        $display("cyc t=%0t rst=%0b stall=%0b redir=%0b tgt=%h -> valid=%0b ifpc=%h instr=%h fault=%0b cnt=%0d",
                 $time, reset, st, rd, tg, a_valid, a_ifpc, a_instr, a_fault, a_cnt);
    endtask

    task automatic async_reset_pulse();
        reset = 1'b1;
        m_reset();
        #2;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("addr8",   32'(a_addr),  32'(m_pc[9:2]));
            check("addr4",   32'(b_addr),  32'(m_pc[5:2]));
            check("valid",   32'(a_valid), 32'(m_valid));
            check("ifpc",    a_ifpc,       m_ifpc);
            check("ifpc4",   a_ifpc4,      m_ifpc4);
            check("instr8",  a_instr,      m_instr8);
            check("instr4",  b_instr,      m_instr4);
            check("fault",   32'(a_fault), 32'(m_fault));
            check("fault_pc", a_fpc,       m_fpc);
            check("cnt",     a_cnt,        m_cnt);
            check("small_valid", 32'(b_valid), 32'(m_valid));
            check("small_cnt",   b_cnt,        m_cnt);
            check("small_fpc",   b_fpc,        m_fpc);
            check("small_ifpc4", b_ifpc4,      m_ifpc4);
            check("small_fault", 32'(b_fault), 32'(m_fault));
            check("small_ifpc",  b_ifpc,       m_ifpc);
        end
    end

    initial begin
        for (int k = 0; k < 256; k++) imem8[k] = 32'(k + 100);
        for (int k = 0; k < 16; k++)  imem4[k] = 32'(k + 100);
        m_reset();
        chk_en = 1'b1;

        // 1: reset held 3 cycles, then asserted again mid-fetch
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        check("rst_valid", 32'(a_valid), 32'h0);
        check("rst_instr", a_instr, 32'h13);
        reset = 1'b0;
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        m_reset();
        #1;
        check("midrst_addr",  32'(a_addr), 32'h0);
        check("midrst_valid", 32'(a_valid), 32'h0);
        check("midrst_instr", a_instr, 32'h13);
        check("midrst_cnt",   a_cnt, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        reset = 1'b0;

        // 2: free run 5 edges
        repeat (5) cycle(1'b0, 1'b0, 32'h0);
        check("run_ifpc",  a_ifpc, 32'd16);
        check("run_instr", a_instr, 32'd104);
        check("run_cnt",   a_cnt, 32'd5);
        check("run_pc4",   a_ifpc4, 32'd20);

        // 3: stall two cycles at pc=8
        async_reset_pulse();
        repeat (2) cycle(1'b0, 1'b0, 32'h0);
        repeat (2) cycle(1'b1, 1'b0, 32'h0);
        check("stall_addr", 32'(a_addr), 32'd2);
        check("stall_ifpc", a_ifpc, 32'd4);
        check("stall_cnt",  a_cnt, 32'd2);
        cycle(1'b0, 1'b0, 32'h0);
        check("resume_ifpc",  a_ifpc, 32'd8);
        check("resume_instr", a_instr, 32'd102);

        // 4: redirect to 0x40 during a stall
        cycle(1'b1, 1'b1, 32'h40);
        check("redir_addr",  32'(a_addr), 32'd16);
        check("redir_valid", 32'(a_valid), 32'h0);
        check("redir_alias", 32'(b_addr), 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check("redir_instr", a_instr, 32'd116);
        check("redir_ifpc",  a_ifpc, 32'h40);

        // 5: misaligned redirect traps
        cycle(1'b0, 1'b1, 32'h42);
        check("trap_addr",   32'(a_addr), 32'd64);
        check("trap_fault",  32'(a_fault), 32'h1);
        check("trap_fpc",    a_fpc, 32'h42);
        check("trap_valid",  32'(a_valid), 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        check("trap_pulse",  32'(a_fault), 32'h0);
        check("trap_hold",   a_fpc, 32'h42);

        // 6: PC wraps at the top of the address space
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 32'h0);
        check("wrap_addr",  32'(a_addr), 32'h0);
        check("wrap_ifpc",  a_ifpc, 32'hFFFF_FFFC);
        check("wrap_pc4",   a_ifpc4, 32'h0);

        // Randomized traffic
        for (int k = 0; k < 256; k++) imem8[k] = $urandom;
        for (int k = 0; k < 16; k++)  imem4[k] = $urandom;
        for (int n = 0; n < 400; n++) begin
            logic        st, rd;
            logic [31:0] tg;
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 9) == 0);
            tg = $urandom;
            if ($urandom_range(0, 3) != 0) tg[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 0) tg = tg & 32'h0000_07FF;
            cycle(st, rd, tg);
            if ($urandom_range(0, 60) == 0) async_reset_pulse();
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
